// File: rtl/gcd_pkg.sv
// Shared GCD definitions: sequencer state encoding and default engine/sequencer sizing.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH      = 16;
  localparam int unsigned GCD_TIMEOUT    = 1023;
  localparam int unsigned GCD_CLR_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    BYPASS,
    LOAD_A,
    LOAD_B,
    WAIT,
    OUT,
    CLEAR
  } gcd_state_e;

endpackage

// File: rtl/gcd_host_sequencer_if.sv
// Host operand/result handshakes plus the engine-side control and data bus.
interface gcd_host_sequencer_if
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic             out_err;
  logic [WIDTH-1:0] core_data;
  logic             core_start;
  logic             core_rst;
  logic             core_done;
  logic [WIDTH-1:0] core_result;
  logic             busy;

  // Host and engine side, as seen from outside the sequencer.
  modport master (
    output in_valid, in_a, in_b, out_ready, core_done, core_result,
    input  in_ready, out_valid, out_gcd, out_err, core_data, core_start, core_rst, busy
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready, core_done, core_result,
    output in_ready, out_valid, out_gcd, out_err, core_data, core_start, core_rst, busy
  );

endinterface

// File: rtl/gcd_timeout_counter.sv
// Saturating cycle counter with synchronous clear; last_o flags the final count of a LIMIT-cycle window.
module gcd_timeout_counter
  import gcd_pkg::*;
#(
  parameter int unsigned LIMIT = GCD_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last_d;

  // last_o is high while cnt_q sits at LIMIT-1 or above, so an enabled window ends after LIMIT cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
    last_d = (cnt_d >= CW'(LIMIT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_o <= (LIMIT <= 1);
    end else begin
      cnt_q  <= cnt_d;
      last_o <= last_d;
    end
  end

endmodule

// File: rtl/gcd_host_sequencer.sv
// Initiator-side GCD controller: feeds operand pairs to the engine, returns results, clears the engine per job.
module gcd_host_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH      = GCD_WIDTH,
  parameter int unsigned TIMEOUT    = GCD_TIMEOUT,
  parameter int unsigned CLR_CYCLES = GCD_CLR_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  gcd_host_sequencer_if.slave  bus
);

  gcd_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             from_core_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_gcd_q;
  logic             out_err_q;
  logic [WIDTH-1:0] core_data_q;
  logic             core_start_q;
  logic             core_rst_q;
  logic             busy_q;

  logic tmo_en;
  logic clr_en;
  logic tmo_last;
  logic clr_last;

  // The clear window also runs in IDLE right after reset, while core_rst is still held.
  assign tmo_en = (state_q == WAIT);
  assign clr_en = (state_q == CLEAR) || ((state_q == IDLE) && core_rst_q);

  gcd_timeout_counter #(.LIMIT(TIMEOUT)) u_tmo_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!tmo_en),
    .en_i   (tmo_en),
    .last_o (tmo_last)
  );

  gcd_timeout_counter #(.LIMIT(CLR_CYCLES)) u_clr_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!clr_en),
    .en_i   (clr_en),
    .last_o (clr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      from_core_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_gcd_q    <= '0;
      out_err_q    <= 1'b0;
      core_data_q  <= '0;
      core_start_q <= 1'b0;
      core_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (core_rst_q) begin
            if (clr_last) begin
              core_rst_q <= 1'b0;
              in_ready_q <= 1'b1;
            end
          end else if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            // Zero operands never terminate in the engine, so they are answered locally.
            if ((bus.in_a == '0) || (bus.in_b == '0)) begin
              state_q <= BYPASS;
            end else begin
              state_q      <= LOAD_A;
              core_data_q  <= bus.in_a;
              core_start_q <= 1'b1;
            end
          end
        end
        BYPASS: begin
          out_gcd_q   <= a_q | b_q;
          out_err_q   <= 1'b0;
          out_valid_q <= 1'b1;
          from_core_q <= 1'b0;
          state_q     <= OUT;
        end
        LOAD_A: begin
          core_data_q  <= b_q;
          core_start_q <= 1'b0;
          state_q      <= LOAD_B;
        end
        LOAD_B: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.core_done) begin
            out_gcd_q   <= bus.core_result;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            from_core_q <= 1'b1;
            state_q     <= OUT;
          end else if (tmo_last) begin
            out_gcd_q   <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            from_core_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (from_core_q) begin
              core_rst_q <= 1'b1;
              state_q    <= CLEAR;
            end else begin
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        CLEAR: begin
          if (clr_last) begin
            core_rst_q <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_gcd    = out_gcd_q;
  assign bus.out_err    = out_err_q;
  assign bus.core_data  = core_data_q;
  assign bus.core_start = core_start_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Directed bench for gcd_host_sequencer with a subtractive GCD engine model on the core bus.
module tb_gcd_host_sequencer;

  localparam int unsigned W   = 16;
  localparam int unsigned TMO = 15;
  localparam int unsigned CLR = 2;

  logic clk = 1'b0;
  logic rst;
  logic hang;

  gcd_host_sequencer_if #(.WIDTH(W)) bus ();

  gcd_host_sequencer #(
    .WIDTH      (W),
    .TIMEOUT    (TMO),
    .CLR_CYCLES (CLR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Engine model: loads A on start, B the cycle after, then subtracts until equal; done is sticky.
  logic [W-1:0] ea, eb;
  logic         edone, eload_b, erun;

  always @(posedge clk) begin
    if (rst || bus.core_rst === 1'b1) begin
      ea <= '0; eb <= '0; edone <= 1'b0; eload_b <= 1'b0; erun <= 1'b0;
    end else if (bus.core_start === 1'b1) begin
      ea <= bus.core_data; eload_b <= 1'b1;
    end else if (eload_b) begin
      eb <= bus.core_data; eload_b <= 1'b0; erun <= 1'b1;
    end else if (erun && !edone && !hang) begin
      if (ea == eb)     edone <= 1'b1;
      else if (ea > eb) ea <= ea - eb;
      else              eb <= eb - ea;
    end
  end

  assign bus.core_done   = edone;
  assign bus.core_result = ea;

  int n_start = 0;
  int n_crst  = 0;
  always @(negedge clk) begin
    if (bus.core_start === 1'b1) n_start <= n_start + 1;
    if (bus.core_rst === 1'b1)   n_crst  <= n_crst + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a pair and return in the cycle after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    check("send_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Step until out_valid; reports cycles taken and the cycle core_done was first seen (-1 if never).
  task automatic wait_out(input string tag, output int cyc, output int dcyc);
    cyc  = 0;
    dcyc = -1;
    while (bus.out_valid !== 1'b1 && cyc < 60) begin
      if (bus.core_done === 1'b1 && dcyc < 0) dcyc = cyc;
      step();
      cyc++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic finish_clear(input string tag);
    bus.out_ready = 1'b1;
    step();
    check({tag, "_clr0"}, {30'd0, bus.core_rst, bus.out_valid}, 32'b10);
    step();
    check({tag, "_clr1"}, {30'd0, bus.core_rst, bus.in_ready}, 32'b10);
    step();
    check({tag, "_idle"}, {29'd0, bus.core_rst, bus.in_ready, bus.busy}, 32'b010);
    bus.out_ready = 1'b0;
  endtask

  int cyc, dcyc, s0, r0, v1, r2, nres;
  logic stable;

  initial begin
    rst = 1'b1; hang = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;

    // Reset values and post-reset engine clear.
    step(); step();
    check("rst_ctrl", {26'd0, bus.in_ready, bus.out_valid, bus.out_err, bus.core_start,
                       bus.busy, bus.core_rst}, 32'b000001);
    check("rst_gcd", 32'(bus.out_gcd), 32'd0);
    check("rst_data", 32'(bus.core_data), 32'd0);
    rst = 1'b0;
    step();
    check("rel_clr1", {30'd0, bus.core_rst, bus.in_ready}, 32'b10);
    step();
    check("rel_idle", {30'd0, bus.core_rst, bus.in_ready}, 32'b01);

    // Basic job 48,18 -> 6.
    send(16'd48, 16'd18);
    check("j1_loada", {14'd0, bus.core_data, bus.core_start, bus.busy}, {14'd0, 16'd48, 2'b11});
    step();
    check("j1_loadb", {15'd0, bus.core_data, bus.core_start}, {15'd0, 16'd18, 1'b0});
    wait_out("j1", cyc, dcyc);
    check("j1_done_lat", 32'(cyc - dcyc), 32'd1);
    check("j1_res", {15'd0, bus.out_gcd, bus.out_err}, {15'd0, 16'd6, 1'b0});
    finish_clear("j1");

    // Zero bypass: engine untouched, result two cycles after accept.
    s0 = n_start; r0 = n_crst;
    send(16'd0, 16'd35);
    check("byp1_c1", 32'(bus.out_valid), 32'd0);
    step();
    check("byp1_res", {14'd0, bus.out_valid, bus.out_gcd, bus.out_err}, {14'd0, 1'b1, 16'd35, 1'b0});
    bus.out_ready = 1'b1;
    step();
    check("byp1_ret", {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
    bus.out_ready = 1'b0;
    send(16'd0, 16'd0);
    step();
    check("byp2_res", {14'd0, bus.out_valid, bus.out_gcd, bus.out_err}, {14'd0, 1'b1, 16'd0, 1'b0});
    bus.out_ready = 1'b1;
    step();
    check("byp2_ret", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    check("byp_core_quiet", 32'((n_start - s0) + (n_crst - r0)), 32'd0);

    // Timeout: engine stalls, out_valid 16 cycles after LOAD_B.
    hang = 1'b1;
    send(16'd7, 16'd3);
    step();
    wait_out("tmo", cyc, dcyc);
    check("tmo_lat", 32'(cyc), 32'(TMO + 1));
    check("tmo_res", {15'd0, bus.out_gcd, bus.out_err}, {15'd0, 16'd0, 1'b1});
    finish_clear("tmo");
    hang = 1'b0;

    // Backpressure: result and in_ready frozen while out_ready is low; new input ignored.
    send(16'd27, 16'd9);
    wait_out("bp", cyc, dcyc);
    bus.in_valid = 1'b1; bus.in_a = 16'd5; bus.in_b = 16'd5;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_gcd !== 16'd9 || bus.in_ready !== 1'b0) stable = 1'b0;
      step();
    end
    bus.in_valid = 1'b0;
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_res", {15'd0, bus.out_gcd, bus.out_valid}, {15'd0, 16'd9, 1'b1});
    finish_clear("bp");

    // Reset in WAIT, then the same job again.
    send(16'd100, 16'd75);
    step(); step(); step();
    rst = 1'b1;
    step();
    check("mid_rst_ctrl", {26'd0, bus.in_ready, bus.out_valid, bus.out_err, bus.core_start,
                           bus.busy, bus.core_rst}, 32'b000001);
    check("mid_rst_data", {bus.out_gcd, bus.core_data}, 32'd0);
    rst = 1'b0;
    step();
    check("mid_rel_clr", {30'd0, bus.core_rst, bus.in_ready}, 32'b10);
    step();
    check("mid_rel_idle", {30'd0, bus.core_rst, bus.in_ready}, 32'b01);
    send(16'd100, 16'd75);
    wait_out("mid", cyc, dcyc);
    check("mid_res", {15'd0, bus.out_gcd, bus.out_err}, {15'd0, 16'd25, 1'b0});
    finish_clear("mid");

    // Back-to-back with out_ready tied high: second pair waits for the first CLEAR.
    bus.out_ready = 1'b1;
    send(16'd12, 16'd8);
    bus.in_valid = 1'b1; bus.in_a = 16'd17; bus.in_b = 16'd5;
    cyc = 0; v1 = -1; r2 = -1; nres = 0;
    for (int k = 0; k < 200 && nres < 2; k++) begin
      if (bus.out_valid === 1'b1) begin
        if (nres == 0) begin
          check("b2b_r1", 32'(bus.out_gcd), 32'd4);
          v1 = cyc;
        end else begin
          check("b2b_r2", 32'(bus.out_gcd), 32'd1);
        end
        nres++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        r2 = cyc;
        step();
        bus.in_valid = 1'b0;
      end else begin
        step();
      end
      cyc++;
    end
    check("b2b_count", 32'(nres), 32'd2);
    check("b2b_accept_gap", 32'(r2 - v1), 32'(CLR + 1));
    step();
    check("b2b_clr", 32'(bus.core_rst), 32'd1);
    step(); step();
    check("b2b_idle", {30'd0, bus.in_ready, bus.busy}, 32'b10);
    bus.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
